// File: rtl/serial_fa_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry loop.
// Operands are consumed LSB-first, one bit per clock. The parallel
// {cout, sum} is published on the completing edge, together with a
// one-cycle done pulse.

// Combinational full-adder cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c0,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ c0;
  assign c = (a & b) | (a & c0) | (b & c0);
endmodule

module serial_fa_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  // The counter indexes bits 0..WIDTH-1. It always has at least 1 bit.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_a, shift_b, psum, psum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c, last;

  fa_cell u_fa (
    .a  (shift_a[0]),
    .b  (shift_b[0]),
    .c0 (carry),
    .s  (fa_s),
    .c  (fa_c)
  );

  // New sum bit enters at the MSB. After WIDTH shifts, the LSB-first
  // stream lands in place. Shift form avoids a null slice at WIDTH=1.
  assign psum_nxt = (psum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign last     = (cnt == CW'(WIDTH - 1));

  // Control FSM and datapath. busy and done are flops set alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      shift_a <= '0;
      shift_b <= '0;
      psum    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shift_a <= a_in;
            shift_b <= b_in;
            carry   <= cin;
            psum    <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          psum    <= psum_nxt;
          carry   <= fa_c;
          cnt     <= cnt + CW'(1);
          if (last) begin
            sum   <= psum_nxt;
            cout  <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_fa_adder.sv
// Self-checking bench for serial_fa_adder at WIDTH=4. It uses a results
// scoreboard, directed vector table, corner sequences and an exhaustive sweep.
module tb_serial_fa_adder;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  serial_fa_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_done = -1;
  bit sweep_on = 1'b0;
  logic [W:0] sb[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard and protocol monitor: every done pops one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [W:0] e;
          e = sb.pop_front();
          check("result", {27'd0, cout, sum}, {27'd0, e});
        end
        if (sweep_on && last_done >= 0)
          check("done_spacing", cyc - last_done, W + 2);
        last_done = cyc;
      end
    end
  end

  // One start pulse. Returns at the negedge where done is seen.
  // Optionally checks that the previous result holds until then.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W:0] exp, input bit chk_hold, input logic [W:0] hold);
    int n, nb;
    bit got;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    sb.push_back(exp);
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        a_in = ~a; b_in = ~b; cin = ~c;  // must not disturb the run
      end
      if (busy) nb++;
      if (done) got = 1'b1;
      else if (chk_hold) check("hold_prev", {27'd0, cout, sum}, {27'd0, hold});
    end
    check("latency", got ? n : 99, W + 1);
    check("busy_cycles", nb, W);
  endtask

  initial begin
    vec_t tv[6];
    int   dcnt, k;
    tv[0] = '{a:4'b0101, b:4'b0011, c:1'b0, s:4'b1000, co:1'b0};
    tv[1] = '{a:4'b1111, b:4'b0001, c:1'b0, s:4'b0000, co:1'b1};
    tv[2] = '{a:4'b1111, b:4'b1111, c:1'b1, s:4'b1111, co:1'b1};
    tv[3] = '{a:4'b0000, b:4'b0000, c:1'b0, s:4'b0000, co:1'b0};
    tv[4] = '{a:4'b1000, b:4'b1000, c:1'b0, s:4'b0000, co:1'b1};
    tv[5] = '{a:4'b0110, b:4'b0101, c:1'b1, s:4'b1100, co:1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", {25'd0, busy, done, cout, sum}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {25'd0, busy, done, cout, sum}, 32'd0);

    // Directed table. tv[2] also checks that the result from tv[1] holds.
    for (int i = 0; i < 6; i++)
      run_op(tv[i].a, tv[i].b, tv[i].c, {tv[i].co, tv[i].s},
             i == 2, {tv[1].co, tv[1].s});

    // Ignored start: a second pulse during RUN must not launch anything.
    @(negedge clk);
    a_in = 4'b0010; b_in = 4'b0010; cin = 1'b0; start = 1'b1;
    sb.push_back(5'b00100);
    @(negedge clk); start = 1'b0;           // after E0
    @(negedge clk); start = 1'b1; a_in = 4'b1111;  // sampled at E2
    @(negedge clk); start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("ignored_start_done_cnt", dcnt, 1);

    // Asynchronous reset mid-operation between E2 and E3.
    @(negedge clk);
    a_in = 4'b0111; b_in = 4'b0001; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("midrst_outputs", {25'd0, busy, done, cout, sum}, 32'd0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst_no_done", dcnt, 0);
    run_op(4'b0001, 4'b0001, 1'b0, 5'b00010, 1'b0, 5'b0);

    // Exhaustive back-to-back sweep, with start held high throughout.
    @(negedge clk);
    last_done = -1;
    sweep_on = 1'b1;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      a_in = v[3:0]; b_in = v[7:4]; cin = v[8]; start = 1'b1;
      sb.push_back(5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]));
      k = 0;
      while (!busy && k < 20) begin @(negedge clk); k++; end
      if (k >= 20) check("sweep_accept_timeout", 32'd1, 32'd0);
      k = 0;
      while (busy && k < 20) begin @(negedge clk); k++; end
      if (k >= 20) check("sweep_done_timeout", 32'd1, 32'd0);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    sweep_on = 1'b0;
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
